// File: rtl/pong_link_pkg.sv
// Shared definitions for the pong board-to-board link: register map,
// control byte and the handoff transmitter state encoding.
package pong_link_pkg;

   typedef logic [2:0] reg_idx_t;

   localparam reg_idx_t REG_Y0    = 3'd0;
   localparam reg_idx_t REG_Y1    = 3'd1;
   localparam reg_idx_t REG_VY    = 3'd2;
   localparam reg_idx_t REG_GRAV  = 3'd3;
   localparam reg_idx_t REG_SPEED = 3'd4;
   localparam reg_idx_t REG_CTRL  = 3'd5;

   localparam logic [7:0] CTRL_GO_RIGHT = 8'h01;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_DONE  = 3'd3,
      S_FAIL  = 3'd4
   } tx_state_t;

   // Select one byte of the six-register packet; unused indices read as zero.
   function automatic logic [7:0] pkt_byte(input logic [5:0][7:0] pkt, input reg_idx_t idx);
      case (idx)
         REG_Y0:    return pkt[0];
         REG_Y1:    return pkt[1];
         REG_VY:    return pkt[2];
         REG_GRAV:  return pkt[3];
         REG_SPEED: return pkt[4];
         REG_CTRL:  return pkt[5];
         default:   return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/handoff_timeout_cnt.sv
// Wait-for-done watchdog: cleared when a command is accepted, counts while
// enabled, and flags the last cycle of the timeout window.
module handoff_timeout_cnt #(
   parameter logic [14:0] LAST = 15'd24999
) (
   input  logic clk_25MHZ,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic expire
);

   logic [14:0] count_r;

   // Clear has priority so every attempt starts a fresh window.
   always_ff @(posedge clk_25MHZ or negedge reset_n) begin
      if (!reset_n) begin
         count_r <= 15'd0;
      end else if (clear) begin
         count_r <= 15'd0;
      end else if (en) begin
         count_r <= count_r + 15'd1;
      end
   end

   assign expire = (count_r == LAST);

endmodule

// File: rtl/ball_handoff_tx.sv
// Snapshots the outgoing ball state on a trigger rising edge and writes it to
// the peer board as six ordered I2C register writes, retrying on NACK/timeout.
module ball_handoff_tx
   import pong_link_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h42,
   parameter int         MAX_RETRY   = 3,
   parameter int         TIMEOUT_CYC = 25000
) (
   input  logic       clk_25MHZ,
   input  logic       reset_n,
   input  logic       ball_send_trigger,
   input  logic [9:0] ball_y,
   input  logic [7:0] ball_vy,
   input  logic [1:0] gravity_phase,
   input  logic [7:0] speed_code,
   output logic       mst_cmd_valid,
   input  logic       mst_cmd_ready,
   output logic [6:0] mst_addr,
   output logic [2:0] mst_reg,
   output logic [7:0] mst_data,
   input  logic       mst_done,
   input  logic       mst_nack,
   output logic       busy,
   output logic       sent_pulse,
   output logic       err_pulse
);

   localparam logic [1:0]  RETRY_LIMIT = 2'(MAX_RETRY);
   localparam logic [14:0] TO_LAST     = 15'(TIMEOUT_CYC - 1);

   tx_state_t        state_r;
   reg_idx_t         idx_r;
   logic [1:0]       retry_r;
   logic [5:0][7:0]  pkt_r;
   logic             trig_q_r;
   logic             cmd_valid_r;
   reg_idx_t         reg_r;
   logic [7:0]       data_r;
   logic             busy_r;
   logic             sent_r;
   logic             err_r;
   logic             start_s;
   logic             accept_s;
   logic             expire_s;

   assign start_s  = ball_send_trigger & ~trig_q_r;
   assign accept_s = (state_r == S_ISSUE) & cmd_valid_r & mst_cmd_ready;

   // Trigger history for rising-edge detection.
   always_ff @(posedge clk_25MHZ or negedge reset_n) begin
      if (!reset_n) begin
         trig_q_r <= 1'b0;
      end else begin
         trig_q_r <= ball_send_trigger;
      end
   end

   handoff_timeout_cnt #(.LAST(TO_LAST)) u_timeout (
      .clk_25MHZ (clk_25MHZ),
      .reset_n   (reset_n),
      .clear     (accept_s),
      .en        (state_r == S_WAIT),
      .expire    (expire_s)
   );

   // Handoff sequencer; each ISSUE spends one cycle loading the command before raising valid.
   always_ff @(posedge clk_25MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= S_IDLE;
         idx_r       <= REG_Y0;
         retry_r     <= 2'd0;
         pkt_r       <= '0;
         cmd_valid_r <= 1'b0;
         reg_r       <= REG_Y0;
         data_r      <= 8'h00;
         busy_r      <= 1'b0;
         sent_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         sent_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start_s) begin
                  pkt_r[0] <= {ball_y[9:8], 6'b000000};
                  pkt_r[1] <= ball_y[7:0];
                  pkt_r[2] <= ball_vy;
                  pkt_r[3] <= {6'b000000, gravity_phase};
                  pkt_r[4] <= speed_code;
                  pkt_r[5] <= CTRL_GO_RIGHT;
                  idx_r    <= REG_Y0;
                  retry_r  <= 2'd0;
                  busy_r   <= 1'b1;
                  state_r  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!cmd_valid_r) begin
                  cmd_valid_r <= 1'b1;
                  reg_r       <= idx_r;
                  data_r      <= pkt_byte(pkt_r, idx_r);
               end else if (mst_cmd_ready) begin
                  cmd_valid_r <= 1'b0;
                  state_r     <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A completion in the same cycle as the timeout takes precedence.
               if (mst_done && !mst_nack) begin
                  if (idx_r == REG_CTRL) begin
                     sent_r  <= 1'b1;
                     state_r <= S_DONE;
                  end else begin
                     idx_r   <= idx_r + 3'd1;
                     retry_r <= 2'd0;
                     state_r <= S_ISSUE;
                  end
               end else if (mst_done || expire_s) begin
                  if (retry_r < RETRY_LIMIT) begin
                     retry_r <= retry_r + 2'd1;
                     state_r <= S_ISSUE;
                  end else begin
                     err_r   <= 1'b1;
                     state_r <= S_FAIL;
                  end
               end
            end
            S_DONE, S_FAIL: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               cmd_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state_r     <= S_IDLE;
            end
         endcase
      end
   end

   assign mst_addr      = SLAVE_ADDR;
   assign mst_cmd_valid = cmd_valid_r;
   assign mst_reg       = reg_r;
   assign mst_data      = data_r;
   assign busy          = busy_r;
   assign sent_pulse    = sent_r;
   assign err_pulse     = err_r;

endmodule
